// File: rtl/dbsched_pkg.sv
// Shared definitions for the debounce scheduler: per-channel state encoding
// and helpers that size the event word.
package dbsched_pkg;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT0 = 2'b01,
        ONE   = 2'b10,
        WAIT1 = 2'b11
    } db_state_t;

    localparam int EVT_FLAG_W = 1;

    function automatic int evt_idx_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int evt_w(input int nch);
        return evt_idx_w(nch) + EVT_FLAG_W;
    endfunction

endpackage

// File: rtl/db_channel.sv
// One debounce channel: four-state FSM with a tick down-counter; emits a
// single-cycle registered press or release request on an accepted edge.
module db_channel
    import dbsched_pkg::*;
#(
    parameter int DB_TICKS = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic i_sw,
    input  logic i_strobe,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int CNT_W = $clog2(DB_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DB_TICKS - 1);

    db_state_t        r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             r_press, w_press_next;
    logic             r_release, w_release_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ZERO;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_press   <= w_press_next;
            r_release <= w_release_next;
        end
    end

    // Entering a WAIT state ignores the strobe; only accepted ticks count down.
    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_press_next   = 1'b0;
        w_release_next = 1'b0;
        case (r_state)
            ZERO: begin
                if (i_sw) begin
                    w_state_next = WAIT1;
                    w_cnt_next   = CNT_LOAD;
                end
            end
            WAIT1: begin
                if (!i_sw) begin
                    w_state_next = ZERO;
                end else if (i_strobe) begin
                    if (r_cnt == '0) begin
                        w_state_next = ONE;
                        w_press_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
            end
            ONE: begin
                if (!i_sw) begin
                    w_state_next = WAIT0;
                    w_cnt_next   = CNT_LOAD;
                end
            end
            WAIT0: begin
                if (i_sw) begin
                    w_state_next = ONE;
                end else if (i_strobe) begin
                    if (r_cnt == '0) begin
                        w_state_next   = ZERO;
                        w_release_next = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt - CNT_W'(1);
                    end
                end
            end
            default: w_state_next = ZERO;
        endcase
    end

    assign o_level   = (r_state == ONE) || (r_state == WAIT0);
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/debounce_scheduler.sv
// Multi-channel switch debouncer with round-robin event queue.
// Define DBSCHED_RELEASE_EVT_EN to also queue release events.
module debounce_scheduler
    import dbsched_pkg::*;
#(
    parameter int  NCH        = 4,
    parameter int  TICK_DIV   = 50000,
    parameter int  DB_TICKS   = 20,
    parameter int  FIFO_DEPTH = 4,
    localparam int CW         = evt_idx_w(NCH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] sw,
    output logic [NCH-1:0] db_level,
    output logic           evt_valid,
    output logic [CW:0]    evt_data,
    input  logic           evt_ready,
    output logic           ovf,
    input  logic           ovf_clr
);

`ifdef DBSCHED_RELEASE_EVT_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif

    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = AW + 1;

    logic [NCH-1:0] r_sync1, r_sync2;
    logic [PW-1:0]  r_presc;
    logic           w_strobe;
    logic [NCH-1:0] w_press, w_rel_raw, w_release, w_req, w_drop, w_grant;
    logic [NCH-1:0] r_pend, r_pflag;
    logic [CW-1:0]  r_ptr, w_gidx, v_sel;
    logic           w_any, w_full, w_push, w_pop, r_ovf;
    logic [CW:0]    r_mem [FIFO_DEPTH];
    logic [CW:0]    w_push_data, w_head;
    logic [AW-1:0]  r_wptr, r_rptr;
    logic [CNTW-1:0] r_count;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign w_strobe = (r_presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_presc <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
            r_presc <= w_strobe ? '0 : r_presc + PW'(1);
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        db_channel #(.DB_TICKS(DB_TICKS)) u_ch (
            .clk       (clk),
            .reset     (reset),
            .i_sw      (r_sync2[gi]),
            .i_strobe  (w_strobe),
            .o_level   (db_level[gi]),
            .o_press   (w_press[gi]),
            .o_release (w_rel_raw[gi])
        );
    end

    assign w_release = w_rel_raw & {NCH{REL_EN}};
    assign w_req     = w_press | w_release;
    assign w_drop    = w_req & r_pend;

    // Search starts one past the last grant so every channel gets a turn.
    always_comb begin
        w_grant = '0;
        w_gidx  = r_ptr;
        w_any   = 1'b0;
        v_sel   = '0;
        if (!w_full) begin
            for (int i = 1; i <= NCH; i++) begin
                v_sel = CW'((int'(r_ptr) + i) % NCH);
                if (!w_any && r_pend[v_sel]) begin
                    w_any  = 1'b1;
                    w_gidx = v_sel;
                end
            end
        end
        w_grant[w_gidx] = w_any;
    end

    assign w_push_data = {r_pflag[w_gidx], w_gidx};
    assign w_full      = (r_count == CNTW'(FIFO_DEPTH));
    assign w_push      = w_any;
    assign w_pop       = evt_valid && evt_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend  <= '0;
            r_pflag <= '0;
            r_ptr   <= CW'(NCH - 1);
            r_ovf   <= 1'b0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_pend  <= (r_pend & ~w_grant) | (w_req & ~r_pend);
            r_pflag <= (r_pflag & ~(w_req & ~r_pend)) | (w_release & ~r_pend);
            if (w_any) begin
                r_ptr <= w_gidx;
            end
            if (ovf_clr) begin
                r_ovf <= 1'b0;
            end else if (|w_drop) begin
                r_ovf <= 1'b1;
            end
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    assign w_head    = r_mem[r_rptr];
    assign evt_valid = (r_count != '0);
    assign evt_data  = {w_head[CW] & REL_EN, w_head[CW-1:0]};
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler (NCH=4, TICK_DIV=4, DB_TICKS=3); a
// negedge monitor checks each accepted event against a queue of expected words.
module tb_debounce_scheduler;
    import dbsched_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw;
    logic [3:0] db_level;
    logic       evt_valid;
    logic [2:0] evt_data;
    logic       evt_ready;
    logic       ovf;
    logic       ovf_clr;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] exp_q[$];

    debounce_scheduler #(
        .NCH(4), .TICK_DIV(4), .DB_TICKS(3), .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .db_level  (db_level),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_ready (evt_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_level(input int ch, input logic val);
        for (int k = 0; k < 200; k++) begin
            if (db_level[ch] === val) break;
            @(negedge clk);
        end
        check($sformatf("level_ch%0d", ch), 32'(db_level[ch]), 32'(val));
    endtask

    // Scoreboard monitor: an accepted head must match the oldest expectation.
    logic [2:0] mon_exp;
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_evt: got %b required none", evt_data);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("evt ch=%0d rel=%0b (expected %b)", evt_data[1:0], evt_data[2], mon_exp);
                check("evt_data", 32'(evt_data), 32'(mon_exp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; sw = 4'b0; evt_ready = 1'b1; ovf_clr = 1'b0;
        cycles(3);
        reset = 1'b0;
        @(negedge clk);
        check("rst_level", 32'(db_level), 0);
        check("rst_valid", 32'(evt_valid), 0);
        check("rst_ovf", 32'(ovf), 0);

        // ch0 and ch2 together with pointer at 3: ch0 first, ch2 next cycle
        sw[0] = 1'b1; sw[2] = 1'b1;
        exp_q.push_back(3'b000);
        exp_q.push_back(3'b010);
        wait_level(0, 1'b1);
        check("level_ch2_same", 32'(db_level[2]), 1);
        @(negedge clk);
        check("lat2_valid_e1", 32'(evt_valid), 0);
        @(negedge clk);
        check("lat2_valid_e2", 32'(evt_valid), 1);
        check("pair_first", 32'(evt_data), 32'(3'b000));
        @(negedge clk);
        check("pair_second", 32'(evt_data), 32'(3'b010));
        check("pair_second_valid", 32'(evt_valid), 1);
        @(negedge clk);
        check("pair_done", 32'(evt_valid), 0);

        sw[0] = 1'b0; sw[2] = 1'b0;
`ifdef DBSCHED_RELEASE_EVT_EN
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b110);
`endif
        wait_level(0, 1'b0);
        cycles(6);

        // ch0 alone: level after 3 strobes, event two cycles later
        sw[0] = 1'b1;
        exp_q.push_back(3'b000);
        wait_level(0, 1'b1);
        @(negedge clk);
        check("lat_valid_e1", 32'(evt_valid), 0);
        @(negedge clk);
        check("lat_valid_e2", 32'(evt_valid), 1);
        check("lat_data", 32'(evt_data), 32'(3'b000));
        sw[0] = 1'b0;
`ifdef DBSCHED_RELEASE_EVT_EN
        exp_q.push_back(3'b100);
`endif
        wait_level(0, 1'b0);
        cycles(6);

        // ch1 glitch shorter than the debounce window
        sw[1] = 1'b1;
        cycles(8);
        sw[1] = 1'b0;
        cycles(20);
        check("glitch_level", 32'(db_level[1]), 0);
        check("glitch_valid", 32'(evt_valid), 0);
        check("glitch_state", 32'(dut.g_ch[1].u_ch.r_state), 32'(ZERO));

        // Fill the FIFO with the consumer stalled
        evt_ready = 1'b0;
        sw[0] = 1'b1; exp_q.push_back(3'b000); wait_level(0, 1'b1); cycles(3);
        sw[1] = 1'b1; exp_q.push_back(3'b001); wait_level(1, 1'b1); cycles(3);
        sw[2] = 1'b1; exp_q.push_back(3'b010); wait_level(2, 1'b1); cycles(3);
`ifdef DBSCHED_RELEASE_EVT_EN
        sw[0] = 1'b0; exp_q.push_back(3'b100); wait_level(0, 1'b0); cycles(3);
`else
        sw[0] = 1'b0; wait_level(0, 1'b0);
        sw[0] = 1'b1; exp_q.push_back(3'b000); wait_level(0, 1'b1); cycles(3);
`endif
        check("full_count", 32'(dut.r_count), 4);
        check("full_head", 32'(evt_data), 32'(3'b000));
        check("full_ovf", 32'(ovf), 0);
        sw[3] = 1'b1; exp_q.push_back(3'b011); wait_level(3, 1'b1); cycles(3);
        check("blocked_count", 32'(dut.r_count), 4);
        check("blocked_ovf", 32'(ovf), 0);
        sw[3] = 1'b0; wait_level(3, 1'b0); cycles(3);
`ifdef DBSCHED_RELEASE_EVT_EN
        check("drop_ovf", 32'(ovf), 1);
`else
        check("release_no_ovf", 32'(ovf), 0);
        sw[3] = 1'b1; wait_level(3, 1'b1); cycles(3);
        check("drop_ovf", 32'(ovf), 1);
`endif
        check("stall_head", 32'(evt_data), 32'(3'b000));
        check("stall_count", 32'(dut.r_count), 4);
        evt_ready = 1'b1;
        cycles(12);
        check("drain_queue", exp_q.size(), 0);
        check("drain_valid", 32'(evt_valid), 0);
        check("ovf_sticky", 32'(ovf), 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(ovf), 0);

        // ch3 release after ONE
`ifdef DBSCHED_RELEASE_EVT_EN
        sw[3] = 1'b1; exp_q.push_back(3'b011); wait_level(3, 1'b1); cycles(6);
        sw[3] = 1'b0; exp_q.push_back(3'b111); wait_level(3, 1'b0); cycles(6);
        check("rel_queue", exp_q.size(), 0);
`else
        sw[3] = 1'b0; wait_level(3, 1'b0); cycles(8);
`endif
        check("rel_valid", 32'(evt_valid), 0);

        // Reset in WAIT1 at count 1 discards the debounce in flight
        sw[3] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (dut.g_ch[3].u_ch.r_state == WAIT1 && dut.g_ch[3].u_ch.r_cnt == 2'd1) break;
            @(negedge clk);
        end
        check("wait1_cnt1", {30'd0, dut.g_ch[3].u_ch.r_cnt}, 1);
        check("wait1_state", 32'(dut.g_ch[3].u_ch.r_state), 32'(WAIT1));
        reset = 1'b1;
        sw = 4'b0;
        cycles(2);
        reset = 1'b0;
        @(negedge clk);
        check("rst2_state", 32'(dut.g_ch[3].u_ch.r_state), 32'(ZERO));
        check("rst2_valid", 32'(evt_valid), 0);
        check("rst2_ovf", 32'(ovf), 0);
        check("rst2_level", 32'(db_level), 0);
        cycles(20);
        check("rst2_no_evt", 32'(evt_valid), 0);
        check("final_queue", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
